ysyx_23060124_rstctrl: RTL

YSYX_23060124_RSTCTRL -- requirements
Module: ysyx_23060124_rstctrl

---
 rtl/ysyx_23060124_rstctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060124_rstctrl.sv
// ysyx_23060124_rstctrl
//
// Sequences the peripheral, memory and core domain resets out of reset and
// orchestrates warm resets requested by software (with a bus-quiesce handshake)
// or by the watchdog.
//
// Sequence: HOLD (all domains in reset) -> REL_P (peripheral released)
//           -> REL_M (memory released) -> RUN (core released).
// Warm reset from RUN: the watchdog goes straight to HOLD; a software request
// first passes through QUIESCE, waiting for the core to drain its bus traffic
// or for a timeout.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset (already i_clk-aligned on release)
//   i_sw_rst_req   software reset request, level-sampled in RUN
//   i_wdt_rst      watchdog reset request, level-sampled in RUN/QUIESCE
//   i_quiesce_ack  core reports bus idle, only honoured in QUIESCE
//   o_periph_rst_n peripheral-domain reset, active-low
//   o_mem_rst_n    memory-domain reset, active-low
//   o_core_rst_n   core-domain reset, active-low
//   o_quiesce_req  asks the core to drain outstanding transactions
//   o_rst_cause    last reset cause: 00 POR, 01 SW, 10 WDT, 11 SW + quiesce timeout
//   o_busy         high whenever the controller is not in RUN
//
// T_HOLD, T_PERIPH, T_MEM and T_QTO must each lie in 1..2^CNT_W-1.

module ysyx_23060124_rstctrl #(
  parameter int unsigned T_HOLD   = 16,
  parameter int unsigned T_PERIPH = 4,
  parameter int unsigned T_MEM    = 8,
  parameter int unsigned T_QTO    = 64,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sw_rst_req,
  input  logic       i_wdt_rst,
  input  logic       i_quiesce_ack,
  output logic       o_periph_rst_n,
  output logic       o_mem_rst_n,
  output logic       o_core_rst_n,
  output logic       o_quiesce_req,
  output logic [1:0] o_rst_cause,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    StHold    = 3'd0,
    StRelP    = 3'd1,
    StRelM    = 3'd2,
    StRun     = 3'd3,
    StQuiesce = 3'd4
  } state_e;

  localparam logic [1:0] CausePor  = 2'b00;
  localparam logic [1:0] CauseSw   = 2'b01;
  localparam logic [1:0] CauseWdt  = 2'b10;
  localparam logic [1:0] CauseSwTo = 2'b11;

  // Terminal counts, sized to the counter so compares use the full width.
  localparam logic [CNT_W-1:0] L_HOLD_LAST   = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_PERIPH_LAST = CNT_W'(T_PERIPH - 1);
  localparam logic [CNT_W-1:0] L_MEM_LAST    = CNT_W'(T_MEM - 1);
  localparam logic [CNT_W-1:0] L_QTO_LAST    = CNT_W'(T_QTO - 1);
  localparam logic [CNT_W-1:0] L_CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_CNT_MAX     = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_d;
  logic             r_periph_rst_n;
  logic             r_mem_rst_n;
  logic             r_core_rst_n;
  logic             r_quiesce_req;
  logic             r_busy;
  logic             w_periph_rst_n_d;
  logic             w_mem_rst_n_d;
  logic             w_core_rst_n_d;
  logic             w_quiesce_req_d;
  logic             w_busy_d;

  // Next-state and cause. Requests are only looked at in RUN and QUIESCE, so a
  // level held through the release sequence acts once RUN is reached.
  always_comb begin
    w_state_d = r_state;
    w_cause_d = r_cause;
    unique case (r_state)
      StHold: begin
        if (r_cnt == L_HOLD_LAST) w_state_d = StRelP;
      end
      StRelP: begin
        if (r_cnt == L_PERIPH_LAST) w_state_d = StRelM;
      end
      StRelM: begin
        if (r_cnt == L_MEM_LAST) w_state_d = StRun;
      end
      StRun: begin
        if (i_wdt_rst) begin
          w_state_d = StHold;
          w_cause_d = CauseWdt;
        end else if (i_sw_rst_req) begin
          w_state_d = StQuiesce;
        end
      end
      StQuiesce: begin
        // Watchdog beats a simultaneous ack; an ack beats a coincident timeout.
        if (i_wdt_rst) begin
          w_state_d = StHold;
          w_cause_d = CauseWdt;
        end else if (i_quiesce_ack) begin
          w_state_d = StHold;
          w_cause_d = CauseSw;
        end else if (r_cnt == L_QTO_LAST) begin
          w_state_d = StHold;
          w_cause_d = CauseSwTo;
        end
      end
      default: begin
        w_state_d = StHold;
      end
    endcase
  end

  // Counter clears on every state change and saturates instead of wrapping.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state) begin
      w_cnt_d = '0;
    end else if (r_cnt != L_CNT_MAX) begin
      w_cnt_d = r_cnt + L_CNT_ONE;
    end
  end

  // Outputs are decoded from the next state so the registered copies change on
  // the same edge as the state itself.
  always_comb begin
    w_periph_rst_n_d = 1'b0;
    w_mem_rst_n_d    = 1'b0;
    w_core_rst_n_d   = 1'b0;
    w_quiesce_req_d  = 1'b0;
    w_busy_d         = 1'b1;
    unique case (w_state_d)
      StRelP: begin
        w_periph_rst_n_d = 1'b1;
      end
      StRelM: begin
        w_periph_rst_n_d = 1'b1;
        w_mem_rst_n_d    = 1'b1;
      end
      StRun: begin
        w_periph_rst_n_d = 1'b1;
        w_mem_rst_n_d    = 1'b1;
        w_core_rst_n_d   = 1'b1;
        w_busy_d         = 1'b0;
      end
      StQuiesce: begin
        w_periph_rst_n_d = 1'b1;
        w_mem_rst_n_d    = 1'b1;
        w_core_rst_n_d   = 1'b1;
        w_quiesce_req_d  = 1'b1;
      end
      default: begin
        w_busy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StHold;
      r_cnt          <= '0;
      r_cause        <= CausePor;
      r_periph_rst_n <= 1'b0;
      r_mem_rst_n    <= 1'b0;
      r_core_rst_n   <= 1'b0;
      r_quiesce_req  <= 1'b0;
      r_busy         <= 1'b1;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_cause        <= w_cause_d;
      r_periph_rst_n <= w_periph_rst_n_d;
      r_mem_rst_n    <= w_mem_rst_n_d;
      r_core_rst_n   <= w_core_rst_n_d;
      r_quiesce_req  <= w_quiesce_req_d;
      r_busy         <= w_busy_d;
    end
  end

  assign o_periph_rst_n = r_periph_rst_n;
  assign o_mem_rst_n    = r_mem_rst_n;
  assign o_core_rst_n   = r_core_rst_n;
  assign o_quiesce_req  = r_quiesce_req;
  assign o_rst_cause    = r_cause;
  assign o_busy         = r_busy;

endmodule
